// File: rtl/bit_diff_arbiter_pkg.sv
// Shared types and helpers for the round-robin bit-difference arbiter.
// rr_pick works on MAX_REQ-wide vectors so that any NUM_REQ below MAX_REQ can share it.
package bit_diff_pkg;

   localparam int MAX_REQ   = 64;
   localparam int MAX_REQ_W = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESP    = 2'd2
   } state_t;

   function automatic int result_width(input int width);
      return $clog2(2 * width + 1);
   endfunction

   // One-hot pick of the first valid requester strictly after `last`, wrapping at num_req.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input int                 last,
                                                  input int                 num_req);
      logic [MAX_REQ-1:0] pick;
      int                 idx;
      pick = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = (last + k >= num_req) ? (last + k - num_req) : (last + k);
         if ((k <= num_req) && (pick == '0) && valid[idx[MAX_REQ_W-1:0]]) begin
            pick[idx[MAX_REQ_W-1:0]] = 1'b1;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/bit_diff_arbiter_if.sv
// Request/response bundle between the producers, the arbiter and the result consumer.
interface bit_diff_if
   import bit_diff_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int RES_W = result_width(WIDTH);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [ID_W-1:0]               resp_id;
   logic signed [RES_W-1:0]       resp_result;
   logic                          busy;
   logic [63:0]                   done_count;

   modport master (
      output req_valid, req_data, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_result, busy, done_count
   );

   modport slave (
      input  req_valid, req_data, resp_ready,
      output req_ready, resp_valid, resp_id, resp_result, busy, done_count
   );
endinterface

// File: rtl/bit_diff_arbiter_engine.sv
// Bit-serial ones-minus-zeros engine: one operand bit per cycle, LSB first.
// done_o/result_o are valid in the cycle the last bit is consumed.
module bit_diff_engine
   import bit_diff_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RES_W = result_width(WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [WIDTH-1:0]        data_i,
   output logic                    done_o,
   output logic signed [RES_W-1:0] result_o
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]        shift_q;
   logic signed [RES_W-1:0] acc_q;
   logic signed [RES_W-1:0] acc_s;
   logic [CNT_W-1:0]        cnt_q;
   logic                    active_q;

   always_comb begin
      if (shift_q[0]) begin
         acc_s = acc_q + RES_W'(1);
      end else begin
         acc_s = acc_q - RES_W'(1);
      end
      done_o   = active_q && (cnt_q == CNT_W'(WIDTH - 1));
      result_o = acc_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         shift_q  <= data_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         acc_q    <= acc_s;
         shift_q  <= shift_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
         active_q <= !done_o;
      end else begin
         shift_q  <= shift_q;
         acc_q    <= acc_q;
         cnt_q    <= cnt_q;
         active_q <= active_q;
      end
   end
endmodule

// File: rtl/bit_diff_arbiter.sv
// Round-robin scheduler sharing one bit-serial bit-difference engine among NUM_REQ requesters.
// Results leave through a registered valid/ready port tagged with the requester index.
module bit_diff_arbiter
   import bit_diff_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
) (
   input logic     clk,
   input logic     rst,
   bit_diff_if.slave bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int RES_W = result_width(WIDTH);

   state_t                  state_q, state_d;
   logic [ID_W-1:0]         last_grant_q, last_grant_d;
   logic [ID_W-1:0]         resp_id_q, resp_id_d;
   logic signed [RES_W-1:0] resp_result_q, resp_result_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    busy_q, busy_d;
   logic [63:0]             done_count_q, done_count_d;

   logic [MAX_REQ-1:0]      valid_ext_s;
   logic [MAX_REQ-1:0]      pick_full_s;
   logic                    pick_ok_s;
   logic [NUM_REQ-1:0]      grant_s;
   logic [ID_W-1:0]         grant_idx_s;
   logic                    handshake_s;
   logic                    eng_done_s;
   logic signed [RES_W-1:0] eng_result_s;

   // A pick outside the populated requester range is treated as no grant.
   always_comb begin
      valid_ext_s                = '0;
      valid_ext_s[NUM_REQ-1:0]   = bus.req_valid;
      pick_full_s                = rr_pick(valid_ext_s, int'(last_grant_q), NUM_REQ);
      pick_ok_s                  = (pick_full_s[MAX_REQ-1:NUM_REQ] == '0);
      if ((state_q == IDLE) && !rst && pick_ok_s) begin
         grant_s = pick_full_s[NUM_REQ-1:0];
      end else begin
         grant_s = '0;
      end
      grant_idx_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            grant_idx_s = ID_W'(i);
         end else begin
            grant_idx_s = grant_idx_s;
         end
      end
      handshake_s = |(bus.req_valid & grant_s);
   end

   bit_diff_engine #(
      .WIDTH (WIDTH),
      .RES_W (RES_W)
   ) u_engine (
      .clk      (clk),
      .rst      (rst),
      .start_i  (handshake_s),
      .data_i   (bus.req_data[grant_idx_s]),
      .done_o   (eng_done_s),
      .result_o (eng_result_s)
   );

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_valid_d  = resp_valid_q;
      done_count_d  = done_count_q;
      case (state_q)
         IDLE: begin
            if (handshake_s) begin
               state_d      = COMPUTE;
               last_grant_d = grant_idx_s;
               resp_id_d    = grant_idx_s;
            end else begin
               state_d = IDLE;
            end
         end
         COMPUTE: begin
            if (eng_done_s) begin
               state_d       = RESP;
               resp_result_d = eng_result_s;
               resp_valid_d  = 1'b1;
            end else begin
               state_d = COMPUTE;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               done_count_d = done_count_q + 64'd1;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Pointer resets to the last index so requester 0 wins the first search.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= ID_W'(NUM_REQ - 1);
         resp_id_q     <= '0;
         resp_result_q <= '0;
         resp_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_count_q  <= 64'd0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_valid_q  <= resp_valid_d;
         busy_q        <= busy_d;
         done_count_q  <= done_count_d;
      end
   end

   assign bus.req_ready   = grant_s;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_id     = resp_id_q;
   assign bus.resp_result = resp_result_q;
   assign bus.busy        = busy_q;
   assign bus.done_count  = done_count_q;
endmodule
